// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter run controller: config registers, iteration counting, run FSM
//
// Purpose:
//   Sequences a PC block through a configured number of iterations. Software
//   loads max/loop/end_addr/iter_target while idle. A start pulse clears the
//   PC block for one cycle and then enables it. Each time the PC block reports
//   a valid PC equal to end_addr, one iteration is counted. The run finishes
//   with a one-cycle done pulse once iter_target iterations have been counted.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   cfg_we     in   config write strobe (honoured only in IDLE)
//   cfg_addr   in   [1:0] 0=max 1=loop 2=end_addr 3=iter_target
//   cfg_wdata  in   [15:0] write data (regs 0-2 use [9:0])
//   start      in   run request (honoured only in IDLE)
//   abort      in   terminate the run from CLEAR or RUN
//   stall      in   suppresses en while high
//   pc_in      in   [9:0] current PC from the PC block
//   pc_rd_conf in   PC-valid flag from the PC block
//   pc_rst     out  active-high clear to the PC block
//   en         out  PC advance enable
//   max        out  [9:0] configured max register
//   loop       out  [9:0] configured loop register
//   busy       out  high whenever not IDLE
//   done       out  one-cycle completion pulse
//   iter_cnt   out  [15:0] iterations completed in the current or last run

module pc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        start,
    input  logic        abort,
    input  logic        stall,
    input  logic [9:0]  pc_in,
    input  logic        pc_rd_conf,
    output logic        pc_rst,
    output logic        en,
    output logic [9:0]  max,
    output logic [9:0]  loop,
    output logic        busy,
    output logic        done,
    output logic [15:0] iter_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [9:0]  max_q;
    logic [9:0]  loop_q;
    logic [9:0]  end_addr_q;
    logic [15:0] iter_target_q;

    // Copies taken at start so the run never depends on live config.
    logic [9:0]  run_end_q;
    logic [15:0] run_target_q;

    logic [15:0] iter_cnt_q;
    logic        pc_rst_q;
    logic        done_q;

    logic        cfg_ok;
    logic        launch;
    logic        match;
    logic        count_hit;
    logic        terminal;
    logic [15:0] iter_inc;
    logic [9:0]  end_addr_nxt;
    logic [15:0] iter_target_nxt;

    assign cfg_ok = cfg_we && (state_q == IDLE);
    assign launch = (state_q == IDLE) && start && !abort;

    // Forward a same-cycle write into the values latched at start, so a
    // write issued together with start takes effect for that run.
    assign end_addr_nxt    = (cfg_ok && cfg_addr == 2'd2) ? cfg_wdata[9:0] : end_addr_q;
    assign iter_target_nxt = (cfg_ok && cfg_addr == 2'd3) ? cfg_wdata      : iter_target_q;

    // A valid match is counted even while stalled: the PC reported here was
    // produced by the previous enabled cycle.
    assign match     = pc_rd_conf && (pc_in == run_end_q);
    assign count_hit = (state_q == RUN) && !abort && match && (iter_cnt_q < run_target_q);
    assign iter_inc  = iter_cnt_q + 16'd1;
    assign terminal  = count_hit && (iter_inc == run_target_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (run_target_q == 16'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pc_rst resets high so the PC block stays cleared until our first edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_rst_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            pc_rst_q <= (state_d == CLEAR);
            done_q   <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q         <= 10'd2;
            loop_q        <= 10'd0;
            end_addr_q    <= 10'd0;
            iter_target_q <= 16'd0;
        end else if (cfg_ok) begin
            case (cfg_addr)
                2'd0:    max_q         <= cfg_wdata[9:0];
                2'd1:    loop_q        <= cfg_wdata[9:0];
                2'd2:    end_addr_q    <= cfg_wdata[9:0];
                default: iter_target_q <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_end_q    <= 10'd0;
            run_target_q <= 16'd0;
            iter_cnt_q   <= 16'd0;
        end else if (launch) begin
            run_end_q    <= end_addr_nxt;
            run_target_q <= iter_target_nxt;
            iter_cnt_q   <= 16'd0;
        end else if (count_hit) begin
            iter_cnt_q   <= iter_inc;
        end
    end

    assign en       = (state_q == RUN) && !stall;
    assign busy     = (state_q != IDLE);
    assign pc_rst   = pc_rst_q;
    assign done     = done_q;
    assign max      = max_q;
    assign loop     = loop_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed self-checking bench for pc_ctrl

module tb_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        start;
    logic        abort;
    logic        stall;
    logic [9:0]  pc_in;
    logic        pc_rd_conf;
    logic        pc_rst;
    logic        en;
    logic [9:0]  max;
    logic [9:0]  loop;
    logic        busy;
    logic        done;
    logic [15:0] iter_cnt;

    int checks = 0;
    int errors = 0;

    pc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .pc_in      (pc_in),
        .pc_rd_conf (pc_rd_conf),
        .pc_rst     (pc_rst),
        .en         (en),
        .max        (max),
        .loop       (loop),
        .busy       (busy),
        .done       (done),
        .iter_cnt   (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic setup_run(input logic [15:0] tgt);
        cfg_write(2'd0, 16'd6);
        cfg_write(2'd1, 16'd1);
        cfg_write(2'd2, 16'd4);
        cfg_write(2'd3, tgt);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = 2'd0;
        cfg_wdata  = 16'd0;
        start      = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        pc_in      = 10'd4;
        pc_rd_conf = 1'b1;

        // Reset: asserted between edges, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk("rst_pc_rst", {15'd0, pc_rst}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_en", {15'd0, en}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_iter", iter_cnt, 16'd0);
        chk("rst_max", {6'd0, max}, 16'd2);
        chk("rst_loop", {6'd0, loop}, 16'd0);
        #9 rst = 1'b1;
        #1;
        chk("rel_pc_rst_hold", {15'd0, pc_rst}, 16'd1);
        tick();
        chk("rel_pc_rst_drop", {15'd0, pc_rst}, 16'd0);
        chk("rel_busy", {15'd0, busy}, 16'd0);

        // Basic run: target 3, match every valid cycle.
        setup_run(16'd3);
        chk("cfg_max", {6'd0, max}, 16'd6);
        chk("cfg_loop", {6'd0, loop}, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_clear_pc_rst", {15'd0, pc_rst}, 16'd1);
        chk("b_clear_busy", {15'd0, busy}, 16'd1);
        chk("b_clear_en", {15'd0, en}, 16'd0);
        tick();
        chk("b_run_pc_rst", {15'd0, pc_rst}, 16'd0);
        chk("b_run_en", {15'd0, en}, 16'd1);
        chk("b_run_iter0", iter_cnt, 16'd0);
        // Write while busy must be ignored.
        cfg_we    = 1'b1;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'd9;
        tick();
        cfg_we = 1'b0;
        chk("b_busy_wr_max", {6'd0, max}, 16'd6);
        chk("b_iter1", iter_cnt, 16'd1);
        chk("b_en1", {15'd0, en}, 16'd1);
        tick();
        chk("b_iter2", iter_cnt, 16'd2);
        chk("b_done_early", {15'd0, done}, 16'd0);
        tick();
        chk("b_iter3", iter_cnt, 16'd3);
        chk("b_done", {15'd0, done}, 16'd1);
        chk("b_done_en", {15'd0, en}, 16'd0);
        chk("b_done_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("b_idle_busy", {15'd0, busy}, 16'd0);
        chk("b_idle_done", {15'd0, done}, 16'd0);
        chk("b_idle_iter", iter_cnt, 16'd3);

        // Stall for 5 cycles mid-run; the first stalled cycle carries a match.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("s_iter1", iter_cnt, 16'd1);
        stall = 1'b1;
        #1;
        chk("s_en_stall0", {15'd0, en}, 16'd0);
        tick();
        chk("s_left_match", iter_cnt, 16'd2);
        pc_rd_conf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s_en_stall", {15'd0, en}, 16'd0);
            chk("s_busy_stall", {15'd0, busy}, 16'd1);
            chk("s_iter_hold", iter_cnt, 16'd2);
        end
        stall      = 1'b0;
        pc_rd_conf = 1'b1;
        #1;
        chk("s_en_resume", {15'd0, en}, 16'd1);
        tick();
        chk("s_iter3", iter_cnt, 16'd3);
        chk("s_done", {15'd0, done}, 16'd1);
        tick();
        chk("s_idle", {15'd0, busy}, 16'd0);

        // Abort at iter_cnt=1 with a same-cycle match.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("a_iter1", iter_cnt, 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_busy", {15'd0, busy}, 16'd0);
        chk("a_done", {15'd0, done}, 16'd0);
        chk("a_iter_hold", iter_cnt, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_restart_clear", {15'd0, pc_rst}, 16'd1);
        chk("a_restart_iter", iter_cnt, 16'd0);
        tick();
        tick();
        tick();
        chk("a_restart_iter2", iter_cnt, 16'd2);
        chk("a_restart_nodone", {15'd0, done}, 16'd0);
        tick();
        chk("a_restart_done", {15'd0, done}, 16'd1);
        chk("a_restart_iter3", iter_cnt, 16'd3);
        tick();

        // Start and abort together in IDLE stay idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", {15'd0, busy}, 16'd0);
        chk("sa_pc_rst", {15'd0, pc_rst}, 16'd0);
        chk("sa_iter", iter_cnt, 16'd3);

        // Write with start in the same cycle: target 2 is used.
        cfg_we    = 1'b1;
        cfg_addr  = 2'd3;
        cfg_wdata = 16'd2;
        start     = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        chk("ws_clear", {15'd0, pc_rst}, 16'd1);
        tick();
        tick();
        chk("ws_iter1", iter_cnt, 16'd1);
        tick();
        chk("ws_iter2", iter_cnt, 16'd2);
        chk("ws_done", {15'd0, done}, 16'd1);
        tick();
        chk("ws_idle", {15'd0, busy}, 16'd0);

        // Zero target: CLEAR then DONE, en never high.
        cfg_write(2'd3, 16'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("z_clear", {15'd0, pc_rst}, 16'd1);
        chk("z_en0", {15'd0, en}, 16'd0);
        chk("z_iter", iter_cnt, 16'd0);
        tick();
        chk("z_done", {15'd0, done}, 16'd1);
        chk("z_en1", {15'd0, en}, 16'd0);
        chk("z_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("z_done_drop", {15'd0, done}, 16'd0);
        chk("z_idle", {15'd0, busy}, 16'd0);

        // Reset mid-run abandons the run and restores defaults.
        setup_run(16'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("r_iter1", iter_cnt, 16'd1);
        rst = 1'b0;
        #1;
        chk("r_busy", {15'd0, busy}, 16'd0);
        chk("r_iter", iter_cnt, 16'd0);
        chk("r_pc_rst", {15'd0, pc_rst}, 16'd1);
        chk("r_max", {6'd0, max}, 16'd2);
        tick();
        #2 rst = 1'b1;
        tick();
        chk("r_rel_pc_rst", {15'd0, pc_rst}, 16'd0);
        chk("r_rel_done", {15'd0, done}, 16'd0);
        chk("r_rel_busy", {15'd0, busy}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
